tensor_core_instruction_arbiter: RTL
====================================

# tensor_core_instruction_arbiter

- Shares the 16-bit tensor core instruction port between two requesters (host loader and DMA/sequencer) and feeds one registered instruction stream to `tensor_core_controller`.
- Arbitration is round-robin, with burst locking so that a multi-instruction sequence is never interleaved.
- It stalls issue while a multi-cycle matrix-multiply instruction is in flight.
- It sits between the instruction sources and the `current_instruction` input of the tensor core controller.

## Interface

**Parameters**
- `INSTR_WIDTH`, default 16: instruction width.
- `MATMUL_OPCODE`, default 4'h5: value of `instruction[15:12]` that identifies a multi-cycle matmul.
- `MATMUL_LATENCY`, default 4: stall cycles after a matmul issues (≥1).
- `BURST_MAX`, default 8: maximum transfers per grant before a forced release (≥1).

**Ports**
- `clock_in`, in, 1: single clock; all logic is on the rising edge.
- `reset_in`, in, 1: asynchronous, active-low reset.
- `req0_instruction`, in, INSTR_WIDTH: requester 0 instruction.
- `req0_valid`, in, 1: requester 0 offers `req0_instruction`.
- `req0_last`, in, 1: marks the final instruction of a requester 0 burst.
- `req0_ready`, out, 1: the arbiter accepts requester 0 this cycle.
- `req1_instruction`, `req1_valid`, `req1_last`, `req1_ready`: same as above, for requester 1.
- `current_instruction`, out, INSTR_WIDTH: instruction presented to the tensor core controller.
- `instruction_valid`, out, 1: `current_instruction` is a new issued instruction this cycle.
- `grant`, out, 2: one-hot owner; `2'b00` means none.
- `busy`, out, 1: a matmul stall is in progress.

## Operation

- The FSM has three states: IDLE, BURST, WAIT.
- **IDLE:**
  - If exactly one requester is valid, it wins.
  - If both are valid, the requester not pointed to by `rr_last` wins. After reset, `rr_last` points to req1, so req0 wins first.
  - The winner sees `ready=1` and the loser `ready=0`. `grant` updates to the winner in the same cycle the transfer happens.
- **Transfer:** occurs on `valid && ready`. On the next clock, `current_instruction` takes the accepted word and `instruction_valid` is 1.
- **Burst lock:**
  - A transfer with `last=0` moves the FSM to BURST and holds the grant.
  - In BURST, only the owner may be ready; the other requester is ignored even if valid.
- **Burst release:** the grant releases on the earliest of:
  - a transfer with `last=1`;
  - the `BURST_MAX`-th transfer of the grant, which forces release even if `last=0`.
- **On release:** `rr_last` is set to the owner, the burst counter clears, and the FSM returns to IDLE (or to WAIT first, if the final word was a matmul).
- **Matmul stall:**
  - A transfer whose `instruction[15:12] == MATMUL_OPCODE` moves the FSM to WAIT for exactly `MATMUL_LATENCY` cycles.
  - In WAIT, both `ready` outputs are 0, `busy=1`, `current_instruction=0`, and `instruction_valid=0`. The grant is held.
  - When WAIT ends, the FSM returns to BURST if the burst is still open, otherwise to IDLE.
- **Idle output:** in any cycle without a transfer, the next `current_instruction` is 16'h0000 (NOP) and `instruction_valid=0`.
- **Owner drops valid in BURST:** the grant is held and a NOP is issued. The lock is not broken.
- **Counter widths:**
  - The burst counter is `$clog2(BURST_MAX+1)` bits.
  - The stall counter is `$clog2(MATMUL_LATENCY+1)` bits.
  - Neither counter wraps; both clear on release or exit.

## Timing

- **Reset values:**
  - `current_instruction`=0, `instruction_valid`=0, `grant`=2'b00, `busy`=0.
  - `req*_ready`=0 while `reset_in`=0.
  - FSM=IDLE, `rr_last`=req1, all counters 0.
- **Reset mid-burst or mid-WAIT:** all state clears immediately; an in-flight matmul stall is abandoned.
- **Latency:** 1 cycle from acceptance to `current_instruction`/`instruction_valid`.
- **Throughput:** 1 instruction per cycle when there are no matmuls.
- **Ready path:** `ready` is combinational from state, owner, and the `valid` inputs only. There is no path from `instruction` to `ready`.
- **Matmul issue rate:** a matmul issues in cycle t, `busy` is 1 for cycles t+1 … t+`MATMUL_LATENCY`, and the next transfer is possible at t+`MATMUL_LATENCY`+1.
- **Simultaneous events:**
  - `last=1` together with matmul: WAIT, then IDLE.
  - `BURST_MAX`-th transfer together with matmul: WAIT, then IDLE with `rr_last` updated.

## Configuration

- **`TENSOR_CORE_ARBITER_STATS_EN` defined:**
  - Adds output ports `req0_issue_count[15:0]`, `req1_issue_count[15:0]`, and `stall_cycle_count[15:0]`.
  - These counters are saturating at 16'hFFFF, cleared by reset, and increment on each transfer per requester and on each WAIT cycle.
- **Macro undefined:** the ports and counters do not exist, and behaviour is otherwise identical.

## Test plan

- **Reset:** hold `reset_in`=0 with both requesters valid → all outputs 0, `ready`=0. Release reset → req0 is granted first.
- **Round-robin:** both valid with `last=1`, non-matmul words 16'h1001/16'h2002 → `current_instruction` alternates 1001, 2002, 1001 on consecutive cycles.
- **Burst lock:** req1 sends 3 words, `last` set on the 3rd, while req0 is valid → req0_ready stays 0 for 3 cycles; req0 is granted on the 4th.
- **Forced release:** req0 streams 10 words with `last=0` and `BURST_MAX`=8 → the grant switches to a waiting req1 after the 8th word.
- **Matmul:** req0 sends 16'h5123, then 16'h1000 → `busy`=1 for 4 cycles with NOP output; 16'h1000 appears 5 cycles after 16'h5123.
- **Async reset during WAIT:** assert `reset_in`=0 in the 2nd stall cycle → `busy` and `grant` clear without waiting for a clock edge.

Source files
------------

// File: rtl/tensor_core_instruction_arbiter.sv
// rtl/tensor_core_instruction_arbiter.sv - two-requester round-robin instruction arbiter with burst lock and matmul stall
//
// Purpose: shares the tensor core instruction port between requester 0 and
// requester 1 and issues one registered instruction stream to
// tensor_core_controller. A burst started by one requester is never
// interleaved. Issue stalls while a multi-cycle matmul is in flight.
//
// Ports:
//   clock_in, reset_in          rising-edge clock, asynchronous active-low reset
//   req0_instruction/valid/last requester 0 offer; req0_ready is the accept
//   req1_instruction/valid/last requester 1 offer; req1_ready is the accept
//   current_instruction         issued word, NOP (0) when nothing was accepted
//   instruction_valid           current_instruction is a newly issued word
//   grant                       one-hot owner, 2'b00 when none
//   busy                        matmul stall in progress
//
// Optional feature macro TENSOR_CORE_ARBITER_STATS_EN adds saturating
// req0_issue_count, req1_issue_count and stall_cycle_count outputs.
module tensor_core_instruction_arbiter #(
    parameter int         INSTR_WIDTH    = 16,
    parameter logic [3:0] MATMUL_OPCODE  = 4'h5,
    parameter int         MATMUL_LATENCY = 4,
    parameter int         BURST_MAX      = 8
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic [INSTR_WIDTH-1:0] req0_instruction,
    input  logic                   req0_valid,
    input  logic                   req0_last,
    output logic                   req0_ready,
    input  logic [INSTR_WIDTH-1:0] req1_instruction,
    input  logic                   req1_valid,
    input  logic                   req1_last,
    output logic                   req1_ready,
    output logic [INSTR_WIDTH-1:0] current_instruction,
    output logic                   instruction_valid,
    output logic [1:0]             grant,
    output logic                   busy
`ifdef TENSOR_CORE_ARBITER_STATS_EN
    ,
    output logic [15:0]            req0_issue_count,
    output logic [15:0]            req1_issue_count,
    output logic [15:0]            stall_cycle_count
`endif
);

    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int SW = $clog2(MATMUL_LATENCY + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX);
    localparam logic [SW-1:0] STALL_LAST = SW'(MATMUL_LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic            owner_q;       // 0 = req0, 1 = req1
    logic            rr_last_q;     // requester that last released a grant
    logic            burst_open_q;  // burst continues after the current stall
    logic [BW-1:0]   burst_cnt_q;
    logic [SW-1:0]   stall_cnt_q;

    logic                   sel;
    logic                   xfer;
    logic [INSTR_WIDTH-1:0] xfer_word;
    logic                   xfer_last;
    logic [BW-1:0]          cnt_next;
    logic                   release_grant;
    logic                   is_matmul;

    // Requester considered this cycle; in BURST/WAIT only the owner counts.
    always_comb begin
        sel = owner_q;
        if (state_q == S_IDLE) begin
            if (req0_valid && req1_valid) begin
                sel = ~rr_last_q;
            end else begin
                sel = req1_valid;
            end
        end
    end

    assign xfer_word     = sel ? req1_instruction : req0_instruction;
    assign xfer_last     = sel ? req1_last : req0_last;
    assign cnt_next      = burst_cnt_q + BW'(1);
    assign release_grant = xfer_last || (cnt_next == BURST_LAST);
    assign is_matmul     = (xfer_word[15:12] == MATMUL_OPCODE);

    // State register
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_BURST: begin
                if (xfer) begin
                    if (is_matmul) begin
                        state_d = S_WAIT;
                    end else if (release_grant) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_BURST;
                    end
                end
            end
            S_WAIT: begin
                if (stall_cnt_q == STALL_LAST) begin
                    state_d = burst_open_q ? S_BURST : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: ready never depends on the instruction words.
    always_comb begin
        req0_ready = reset_in && (state_q != S_WAIT) && !sel && req0_valid;
        req1_ready = reset_in && (state_q != S_WAIT) && sel && req1_valid;
        xfer       = req0_ready || req1_ready;
        busy       = (state_q == S_WAIT);
        grant      = 2'b00;
        if (reset_in) begin
            if (state_q == S_IDLE) begin
                if (xfer) begin
                    grant = sel ? 2'b10 : 2'b01;
                end
            end else begin
                grant = owner_q ? 2'b10 : 2'b01;
            end
        end
    end

    // Issue register, grant bookkeeping and counters
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            current_instruction <= '0;
            instruction_valid   <= 1'b0;
            owner_q             <= 1'b0;
            rr_last_q           <= 1'b1;
            burst_open_q        <= 1'b0;
            burst_cnt_q         <= '0;
            stall_cnt_q         <= '0;
        end else begin
            current_instruction <= xfer ? xfer_word : '0;
            instruction_valid   <= xfer;
            if (xfer) begin
                owner_q      <= sel;
                burst_open_q <= !release_grant;
                if (release_grant) begin
                    rr_last_q   <= sel;
                    burst_cnt_q <= '0;
                end else begin
                    burst_cnt_q <= cnt_next;
                end
            end
            if (state_q == S_WAIT) begin
                stall_cnt_q <= (stall_cnt_q == STALL_LAST) ? '0 : stall_cnt_q + SW'(1);
            end
        end
    end

`ifdef TENSOR_CORE_ARBITER_STATS_EN
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            req0_issue_count  <= '0;
            req1_issue_count  <= '0;
            stall_cycle_count <= '0;
        end else begin
            if (req0_ready && (req0_issue_count != 16'hFFFF)) begin
                req0_issue_count <= req0_issue_count + 16'd1;
            end
            if (req1_ready && (req1_issue_count != 16'hFFFF)) begin
                req1_issue_count <= req1_issue_count + 16'd1;
            end
            if (busy && (stall_cycle_count != 16'hFFFF)) begin
                stall_cycle_count <= stall_cycle_count + 16'd1;
            end
        end
    end
`endif

endmodule
